// File: rtl/ffe_sample_feeder_if.sv
// Sample-in / tap-read bus between the FFE sample feeder and its neighbours.
// The slave modport is the feeder side; master is the upstream source plus datapath side.
interface ffe_sample_feeder_if #(
    parameter int IN_OUT_BUS_WIDTH = 12,
    parameter int ADDR_SIZE        = 2
);
    // x_valid/x_ready: a sample transfers on a rising ffe_clk edge where both are 1.
    // x_in is held stable while x_valid is 1. x_ready depends only on registered
    // state, never on x_valid.
    logic signed [IN_OUT_BUS_WIDTH-1:0] x_in;
    logic                               x_valid;
    logic                               x_ready;
    logic        [ADDR_SIZE-1:0]        rd_addr;
    logic signed [IN_OUT_BUS_WIDTH-1:0] rd_data;
    logic                               str_out_n_rst_add_reg;
    logic                               y_valid;
    logic                               overrun;
    logic                               dbg_state;  // 0 = IDLE, 1 = RUN

    modport master (
        output x_in, x_valid,
        input  x_ready, rd_addr, rd_data, str_out_n_rst_add_reg, y_valid, overrun, dbg_state
    );

    modport slave (
        input  x_in, x_valid,
        output x_ready, rd_addr, rd_data, str_out_n_rst_add_reg, y_valid, overrun, dbg_state
    );
endinterface

// File: rtl/ffe_sample_feeder.sv
// Keeps the last DEPTH input samples and plays one frame of DEPTH tap reads per sample.
// Define FFE_FEEDER_OVERRUN_EN to flag (sticky) samples dropped while x_ready is low.
module ffe_sample_feeder #(
    parameter int IN_OUT_BUS_WIDTH = 12,
    parameter int DEPTH            = 4,   // must be a power of 2
    parameter int ADDR_SIZE        = $clog2(DEPTH)
) (
    input  logic                  ffe_clk,
    input  logic                  rst,
    ffe_sample_feeder_if.slave    bus
);
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [ADDR_SIZE-1:0] LAST_TAP = ADDR_SIZE'(DEPTH - 1);
    localparam logic [ADDR_SIZE-1:0] ONE      = ADDR_SIZE'(1);

    state_t                             state;
    logic        [ADDR_SIZE-1:0]        wr_ptr;
    logic        [ADDR_SIZE-1:0]        tap_cnt;
    logic        [ADDR_SIZE-1:0]        rd_ptr;
    logic signed [IN_OUT_BUS_WIDTH-1:0] hist [DEPTH];
    logic                               str_q;
    logic                               overrun_q;
    logic                               at_last;
    logic                               x_ready;
    logic                               accept;

    assign at_last = (tap_cnt == LAST_TAP);
    assign x_ready = (state == IDLE) || at_last;
    assign accept  = bus.x_valid && x_ready;

    // Newest sample lives at wr_ptr-1; pointer arithmetic wraps because DEPTH is 2^ADDR_SIZE.
    assign rd_ptr  = wr_ptr - ONE - tap_cnt;

    assign bus.x_ready               = x_ready;
    assign bus.rd_addr               = (state == RUN) ? tap_cnt : '0;
    assign bus.rd_data               = (state == RUN) ? hist[rd_ptr] : '0;
    assign bus.str_out_n_rst_add_reg = str_q;
    assign bus.y_valid               = str_q;
    assign bus.overrun               = overrun_q;
    assign bus.dbg_state             = state;

    always_ff @(posedge ffe_clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            wr_ptr  <= '0;
            tap_cnt <= '0;
            str_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                hist[i] <= '0;
            end
        end else begin
            // Strobe lands one cycle after the last tap, when the datapath sum is complete.
            str_q <= (state == RUN) && at_last;

            if (accept) begin
                hist[wr_ptr] <= bus.x_in;
                wr_ptr       <= wr_ptr + ONE;
            end

            case (state)
                IDLE: begin
                    tap_cnt <= '0;
                    if (accept) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (at_last) begin
                        tap_cnt <= '0;
                        if (!accept) begin
                            state <= IDLE;
                        end
                    end else begin
                        tap_cnt <= tap_cnt + ONE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    tap_cnt <= '0;
                end
            endcase
        end
    end

`ifdef FFE_FEEDER_OVERRUN_EN
    // Free-running source: a valid sample offered while not ready is lost.
    always_ff @(posedge ffe_clk or negedge rst) begin
        if (!rst) begin
            overrun_q <= 1'b0;
        end else if (bus.x_valid && !x_ready) begin
            overrun_q <= 1'b1;
        end
    end
`else
    assign overrun_q = 1'b0;
`endif

endmodule

// File: tb/tb_ffe_sample_feeder.sv
// Directed bench for ffe_sample_feeder: frame timing, history wrap, datapath sums, reset.
module tb_ffe_sample_feeder;
    localparam int W     = 12;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic clk;
    logic rst;
    int   total;
    int   bad;

`ifdef FFE_FEEDER_OVERRUN_EN
    localparam logic EXP_OVR = 1'b1;
`else
    localparam logic EXP_OVR = 1'b0;
`endif

    ffe_sample_feeder_if #(.IN_OUT_BUS_WIDTH(W), .ADDR_SIZE(AW)) fif ();

    ffe_sample_feeder #(
        .IN_OUT_BUS_WIDTH(W),
        .DEPTH           (DEPTH),
        .ADDR_SIZE       (AW)
    ) dut (
        .ffe_clk(clk),
        .rst    (rst),
        .bus    (fif)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst         = 1'b0;
        fif.x_valid = 1'b0;
        fif.x_in    = '0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < 20; c++) begin
            total++;
            if (fif.x_ready !== 1'b1 || fif.rd_addr !== 2'd0 || fif.rd_data !== 12'sd0 ||
                fif.str_out_n_rst_add_reg !== 1'b0 || fif.y_valid !== 1'b0 ||
                fif.overrun !== 1'b0 || fif.dbg_state !== 1'b0) begin
                bad++;
                $display("FAIL reset_idle c=%0d got rdy=%b addr=%0d data=%0d str=%b yv=%b ovr=%b st=%b exp 1 0 0 0 0 0 0",
                         c, fif.x_ready, fif.rd_addr, fif.rd_data, fif.str_out_n_rst_add_reg,
                         fif.y_valid, fif.overrun, fif.dbg_state);
            end
            tick();
        end
    endtask

    task automatic test_single();
        logic signed [W-1:0] exp_d;
        do_reset();
        fif.x_valid = 1'b1;
        fif.x_in    = 12'sh100;
        tick();
        fif.x_valid = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            exp_d = (k == 0) ? 12'sh100 : 12'sd0;
            total++;
            if (fif.rd_addr !== AW'(k) || fif.rd_data !== exp_d ||
                fif.x_ready !== (k == DEPTH - 1) || fif.str_out_n_rst_add_reg !== 1'b0) begin
                bad++;
                $display("FAIL single_tap k=%0d got addr=%0d data=%0d rdy=%b str=%b exp addr=%0d data=%0d rdy=%b str=0",
                         k, fif.rd_addr, fif.rd_data, fif.x_ready, fif.str_out_n_rst_add_reg,
                         k, exp_d, (k == DEPTH - 1));
            end
            tick();
        end
        total++;
        if (fif.str_out_n_rst_add_reg !== 1'b1 || fif.y_valid !== 1'b1 || fif.dbg_state !== 1'b0 ||
            fif.rd_addr !== 2'd0 || fif.rd_data !== 12'sd0 || fif.x_ready !== 1'b1) begin
            bad++;
            $display("FAIL single_strobe got str=%b yv=%b st=%b addr=%0d data=%0d rdy=%b exp 1 1 0 0 0 1",
                     fif.str_out_n_rst_add_reg, fif.y_valid, fif.dbg_state, fif.rd_addr,
                     fif.rd_data, fif.x_ready);
        end
        tick();
        total++;
        if (fif.str_out_n_rst_add_reg !== 1'b0) begin
            bad++;
            $display("FAIL single_strobe_width got str=%b exp 0", fif.str_out_n_rst_add_reg);
        end
    endtask

    // Datapath: accumulator loads the current product on strobe, else accumulates; y = acc >>> 11.
    task automatic test_impulse();
        int     taps   [DEPTH] = '{1024, -512, 320, -128};
        int     samples[DEPTH] = '{1024, 0, 0, 0};
        longint exp_y  [DEPTH] = '{512, -256, 160, -64};
        longint acc;
        longint prod;
        longint y;
        int     idx;
        int     nstr;
        int     last_c;
        do_reset();
        acc = 0; idx = 0; nstr = 0; last_c = 0;
        for (int c = 0; c < 40; c++) begin
            prod = longint'(taps[fif.rd_addr]) * longint'(fif.rd_data);
            if (fif.str_out_n_rst_add_reg === 1'b1) begin
                y = acc >>> 11;
                if (nstr < DEPTH) begin
                    total++;
                    if (y != exp_y[nstr]) begin
                        bad++;
                        $display("FAIL impulse_y n=%0d got %0d exp %0d", nstr, y, exp_y[nstr]);
                    end
                end
                if (nstr > 0) begin
                    total++;
                    if (c - last_c != DEPTH) begin
                        bad++;
                        $display("FAIL impulse_spacing n=%0d got %0d exp %0d", nstr, c - last_c, DEPTH);
                    end
                end
                last_c = c;
                nstr++;
                acc = prod;
            end else begin
                acc = acc + prod;
            end
            if (idx < DEPTH && fif.x_ready === 1'b1) begin
                fif.x_valid = 1'b1;
                fif.x_in    = W'(samples[idx]);
                idx++;
            end else begin
                fif.x_valid = 1'b0;
            end
            tick();
        end
        total++;
        if (nstr != DEPTH) begin
            bad++;
            $display("FAIL impulse_strobe_count got %0d exp %0d", nstr, DEPTH);
        end
    endtask

    task automatic test_wrap();
        int frame;
        int idx;
        int e;
        do_reset();
        frame = 0; idx = 1;
        for (int c = 0; c < 40; c++) begin
            if (fif.dbg_state === 1'b1) begin
                if (fif.rd_addr === 2'd0) frame++;
                e = frame - int'(fif.rd_addr);
                if (e < 0) e = 0;
                total++;
                if (fif.rd_data !== W'(e)) begin
                    bad++;
                    $display("FAIL wrap_data frame=%0d tap=%0d got %0d exp %0d",
                             frame, fif.rd_addr, fif.rd_data, e);
                end
            end
            if (idx <= 6 && fif.x_ready === 1'b1) begin
                fif.x_valid = 1'b1;
                fif.x_in    = W'(idx);
                idx++;
            end else begin
                fif.x_valid = 1'b0;
            end
            tick();
        end
        total++;
        if (frame != 6) begin
            bad++;
            $display("FAIL wrap_frames got %0d exp 6", frame);
        end
    endtask

    task automatic test_back_to_back_hold();
        do_reset();
        fif.x_valid = 1'b1;
        fif.x_in    = 12'sh010;
        tick();
        fif.x_in = 12'sh022;
        for (int k = 0; k < DEPTH; k++) begin
            total++;
            if (fif.x_ready !== (k == DEPTH - 1) || fif.rd_addr !== AW'(k)) begin
                bad++;
                $display("FAIL hold_ready k=%0d got rdy=%b addr=%0d exp rdy=%b addr=%0d",
                         k, fif.x_ready, fif.rd_addr, (k == DEPTH - 1), k);
            end
            tick();
        end
        fif.x_valid = 1'b0;
        total++;
        if (fif.dbg_state !== 1'b1 || fif.rd_addr !== 2'd0 || fif.rd_data !== 12'sh022 ||
            fif.str_out_n_rst_add_reg !== 1'b1) begin
            bad++;
            $display("FAIL hold_next_frame got st=%b addr=%0d data=%0d str=%b exp 1 0 34 1",
                     fif.dbg_state, fif.rd_addr, fif.rd_data, fif.str_out_n_rst_add_reg);
        end
        tick();
        total++;
        if (fif.rd_addr !== 2'd1 || fif.rd_data !== 12'sh010 || fif.overrun !== EXP_OVR) begin
            bad++;
            $display("FAIL hold_tap1 got addr=%0d data=%0d ovr=%b exp 1 16 %b",
                     fif.rd_addr, fif.rd_data, fif.overrun, EXP_OVR);
        end
        tick();
        total++;
        if (fif.rd_data !== 12'sd0) begin
            bad++;
            $display("FAIL hold_tap2 got data=%0d exp 0", fif.rd_data);
        end
    endtask

    task automatic test_overrun();
        do_reset();
        fif.x_valid = 1'b1;
        fif.x_in    = 12'sh040;
        tick();
        fif.x_valid = 1'b0;
        tick();
        fif.x_valid = 1'b1;   // tap 1: not ready
        fif.x_in    = 12'sh099;
        tick();
        fif.x_valid = 1'b0;
        total++;
        if (fif.overrun !== EXP_OVR || fif.rd_addr !== 2'd2) begin
            bad++;
            $display("FAIL overrun_set got ovr=%b addr=%0d exp %b 2", fif.overrun, fif.rd_addr, EXP_OVR);
        end
        tick();
        tick();
        total++;
        if (fif.overrun !== EXP_OVR || fif.str_out_n_rst_add_reg !== 1'b1 || fif.dbg_state !== 1'b0) begin
            bad++;
            $display("FAIL overrun_sticky got ovr=%b str=%b st=%b exp %b 1 0",
                     fif.overrun, fif.str_out_n_rst_add_reg, fif.dbg_state, EXP_OVR);
        end
        fif.x_valid = 1'b1;
        fif.x_in    = 12'sh041;
        tick();
        fif.x_valid = 1'b0;
        total++;
        if (fif.rd_data !== 12'sh041) begin
            bad++;
            $display("FAIL overrun_tap0 got %0d exp 65", fif.rd_data);
        end
        tick();
        total++;
        if (fif.rd_data !== 12'sh040) begin
            bad++;
            $display("FAIL overrun_tap1 got %0d exp 64", fif.rd_data);
        end
        tick();
        total++;
        if (fif.rd_data !== 12'sd0 || fif.overrun !== EXP_OVR) begin
            bad++;
            $display("FAIL overrun_tap2 got data=%0d ovr=%b exp 0 %b", fif.rd_data, fif.overrun, EXP_OVR);
        end
        do_reset();
        total++;
        if (fif.overrun !== 1'b0) begin
            bad++;
            $display("FAIL overrun_clear got %b exp 0", fif.overrun);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic signed [W-1:0] exp_d;
        do_reset();
        fif.x_valid = 1'b1;
        fif.x_in    = 12'sh077;
        tick();
        fif.x_valid = 1'b0;
        tick();
        tick();
        total++;
        if (fif.rd_addr !== 2'd2) begin
            bad++;
            $display("FAIL midrst_pre got addr=%0d exp 2", fif.rd_addr);
        end
        #1 rst = 1'b0;
        #1;
        total++;
        if (fif.x_ready !== 1'b1 || fif.rd_addr !== 2'd0 || fif.rd_data !== 12'sd0 ||
            fif.str_out_n_rst_add_reg !== 1'b0 || fif.dbg_state !== 1'b0) begin
            bad++;
            $display("FAIL midrst_async got rdy=%b addr=%0d data=%0d str=%b st=%b exp 1 0 0 0 0",
                     fif.x_ready, fif.rd_addr, fif.rd_data, fif.str_out_n_rst_add_reg, fif.dbg_state);
        end
        tick();
        rst = 1'b1;
        for (int c = 0; c < 8; c++) begin
            total++;
            if (fif.str_out_n_rst_add_reg !== 1'b0) begin
                bad++;
                $display("FAIL midrst_no_strobe c=%0d got 1 exp 0", c);
            end
            tick();
        end
        fif.x_valid = 1'b1;
        fif.x_in    = 12'sh033;
        tick();
        fif.x_valid = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            exp_d = (k == 0) ? 12'sh033 : 12'sd0;
            total++;
            if (fif.rd_addr !== AW'(k) || fif.rd_data !== exp_d) begin
                bad++;
                $display("FAIL midrst_restart k=%0d got addr=%0d data=%0d exp %0d %0d",
                         k, fif.rd_addr, fif.rd_data, k, exp_d);
            end
            tick();
        end
        total++;
        if (fif.str_out_n_rst_add_reg !== 1'b1) begin
            bad++;
            $display("FAIL midrst_strobe got 0 exp 1");
        end
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        rst         = 1'b0;
        fif.x_valid = 1'b0;
        fif.x_in    = '0;
        test_reset();
        test_single();
        test_impulse();
        test_wrap();
        test_back_to_back_hold();
        test_overrun();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
